// File: rtl/rf_serial_driver.sv
// Serialises parallel read/write commands onto the 32x64 serial register-file stage.
// Define RF_DRV_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module rf_serial_driver #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rf_sdi,
  output logic              rf_ld,
  output logic              rf_st,
  input  logic              rf_sdo
);

  localparam int SH_W = DATA_W + ADDR_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SHIFT = 3'd1;
  localparam logic [2:0] S_WR_STB   = 3'd2;
  localparam logic [2:0] S_RD_ADDR  = 3'd3;
  localparam logic [2:0] S_RD_LD    = 3'd4;
  localparam logic [2:0] S_RD_DRAIN = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  localparam logic [6:0] CNT_WR = 7'(SH_W - 1);
  localparam logic [6:0] CNT_RA = 7'(ADDR_W - 1);
  localparam logic [6:0] CNT_DR = 7'(DATA_W - 1);

  logic [2:0]        r_state;
  logic [6:0]        r_count;
  logic [SH_W-1:0]   r_shadow;
  logic [DATA_W-1:0] r_rspData;
  logic [2:0]        w_nextState;
  logic [6:0]        w_nextCount;
  logic              w_last;

`ifdef RF_DRV_VERIFY_EN
  logic r_isWrite;
  logic r_rspErr;
`endif

  assign w_last = (r_count == 7'd0);

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nextState = cmd_write ? S_WR_SHIFT : S_RD_ADDR;
          w_nextCount = cmd_write ? CNT_WR : CNT_RA;
        end
      end
      S_WR_SHIFT: begin
        if (w_last) begin
          w_nextState = S_WR_STB;
          w_nextCount = 7'd0;
        end else begin
          w_nextCount = r_count - 7'd1;
        end
      end
      S_WR_STB: begin
`ifdef RF_DRV_VERIFY_EN
        // The address is still resident in the stage, so load straight back.
        w_nextState = S_RD_LD;
`else
        w_nextState = S_RESP;
`endif
        w_nextCount = 7'd0;
      end
      S_RD_ADDR: begin
        if (w_last) begin
          w_nextState = S_RD_LD;
          w_nextCount = 7'd0;
        end else begin
          w_nextCount = r_count - 7'd1;
        end
      end
      S_RD_LD: begin
        w_nextState = S_RD_DRAIN;
        w_nextCount = CNT_DR;
      end
      S_RD_DRAIN: begin
        if (w_last) begin
          w_nextState = S_RESP;
          w_nextCount = 7'd0;
        end else begin
          w_nextCount = r_count - 7'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_nextState = S_IDLE;
          w_nextCount = 7'd0;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCount = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 7'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_rspData <= '0;
`ifdef RF_DRV_VERIFY_EN
      r_isWrite <= 1'b0;
      r_rspErr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_shadow <= {cmd_data, cmd_addr};
            if (cmd_write) r_rspData <= cmd_data;
`ifdef RF_DRV_VERIFY_EN
            r_isWrite <= cmd_write;
            r_rspErr  <= 1'b0;
`endif
          end
        end
        S_WR_SHIFT, S_RD_ADDR: r_shadow <= r_shadow << 1;
        S_RD_DRAIN: begin
          r_rspData <= {r_rspData[DATA_W-2:0], rf_sdo};
`ifdef RF_DRV_VERIFY_EN
          // The written word leaves the MSB in the same order the readback arrives.
          r_rspErr <= r_rspErr | (r_isWrite & (rf_sdo != r_rspData[DATA_W-1]));
`endif
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rspData;
  assign rf_ld     = (r_state == S_RD_LD);
  assign rf_st     = (r_state == S_WR_STB);
  assign rf_sdi    = (r_state == S_WR_SHIFT) ? r_shadow[SH_W-1] :
                     (r_state == S_RD_ADDR)  ? r_shadow[ADDR_W-1] : 1'b0;

`ifdef RF_DRV_VERIFY_EN
  assign rsp_err = r_rspErr;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_serial_driver.sv
// Bench for rf_serial_driver: behavioural register-file stage, reference memory model,
// table vectors, corner-case sequences and randomized commands.
module tb_rf_serial_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        rf_sdi;
  logic        rf_ld;
  logic        rf_st;
  logic        rf_sdo;

`ifdef RF_DRV_VERIFY_EN
  localparam int WR_RSP_CYC = 136;
`else
  localparam int WR_RSP_CYC = 71;
`endif

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  rf_serial_driver #(.ADDR_W(5), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rf_sdi(rf_sdi), .rf_ld(rf_ld), .rf_st(rf_st), .rf_sdo(rf_sdo)
  );

  // Behavioural stage: 69-bit {data,addr} shifter that shifts whenever no strobe is up.
  logic [63:0] stageMem [32] = '{default: 64'd0};
  logic [68:0] stageSr = '0;
  bit          forceSdoZero = 1'b0;
  assign rf_sdo = forceSdoZero ? 1'b0 : stageSr[68];

  always @(posedge clk) begin
    if (rf_ld)      stageSr[68:5] <= stageMem[stageSr[4:0]];
    else if (rf_st) stageMem[stageSr[4:0]] <= stageSr[68:5];
    else            stageSr <= {stageSr[67:0], rf_sdi};
  end

  logic [63:0] refMem [32] = '{default: 64'd0};

  int   ldCount = 0, stCount = 0, overlapCount = 0, widthErrCount = 0;
  logic prevLd = 1'b0, prevSt = 1'b0;
  always @(negedge clk) begin
    if (rf_ld && rf_st) overlapCount++;
    if (rf_ld && prevLd) widthErrCount++;
    if (rf_st && prevSt) widthErrCount++;
    if (rf_ld) ldCount++;
    if (rf_st) stCount++;
    prevLd = rf_ld;
    prevSt = rf_st;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit wr, input logic [4:0] a, input logic [63:0] d,
                               input int hold, input string tag,
                               output logic [63:0] rspD, output logic rspE,
                               output int rspCyc, output int stCyc, output int ldCyc);
    int waitN;
    rspCyc = 0; stCyc = 0; ldCyc = 0; waitN = 0;
    rsp_ready = (hold == 0);
    @(negedge clk);
    while (!cmd_ready && waitN < 300) begin
      @(negedge clk);
      waitN++;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = {$urandom, $urandom};
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (rf_st && stCyc == 0) stCyc = c;
      if (rf_ld && ldCyc == 0) ldCyc = c;
      if (rsp_valid) begin
        rspCyc = c;
        break;
      end
    end
    checkOutput({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    rspD = rsp_data;
    rspE = rsp_err;
    for (int h = 0; h < hold; h++) begin
      checkOutput($sformatf("%s hold%0d valid", tag, h), 64'(rsp_valid), 64'd1);
      checkOutput($sformatf("%s hold%0d data", tag, h), rsp_data, rspD);
      checkOutput($sformatf("%s hold%0d cmd_ready", tag, h), 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " rsp consumed"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic doCmd(input bit wr, input logic [4:0] a, input logic [63:0] d,
                       input logic [63:0] expRsp, input logic expErr, input int hold,
                       input string tag);
    logic [63:0] rspD;
    logic        rspE;
    int          rspCyc, stCyc, ldCyc;
    applyStimulus(wr, a, d, hold, tag, rspD, rspE, rspCyc, stCyc, ldCyc);
    checkOutput({tag, " data"}, rspD, expRsp);
    checkOutput({tag, " err"}, 64'(rspE), 64'(expErr));
    checkOutput({tag, " rsp cycle"}, 64'(rspCyc), wr ? 64'(WR_RSP_CYC) : 64'd71);
    if (wr) checkOutput({tag, " st cycle"}, 64'(stCyc), 64'd70);
    else    checkOutput({tag, " ld cycle"}, 64'(ldCyc), 64'd6);
`ifdef RF_DRV_VERIFY_EN
    if (wr) checkOutput({tag, " verify ld cycle"}, 64'(ldCyc), 64'd71);
`endif
    if (wr) refMem[a] = d;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] expRsp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rvCount, ld0, st0;
    bit          rWr;
    logic [4:0]  rAddr;
    logic [63:0] rData;

    vecs[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vecs[1] = '{1'b0, 5'd5,  64'h0,                 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    vecs[3] = '{1'b1, 5'd0,  64'h0,                 64'h0};
    vecs[4] = '{1'b0, 5'd31, 64'h0,                 64'hFFFFFFFF_FFFFFFFF};
    vecs[5] = '{1'b0, 5'd0,  64'h0,                 64'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset rsp_err",   64'(rsp_err),   64'd0);
    checkOutput("reset rf_sdi",    64'(rf_sdi),    64'd0);
    checkOutput("reset rf_ld",     64'(rf_ld),     64'd0);
    checkOutput("reset rf_st",     64'(rf_st),     64'd0);
    checkOutput("reset rsp_data",  rsp_data,       64'd0);

    for (int i = 0; i < 6; i++)
      doCmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].expRsp, 1'b0, 0,
            $sformatf("vec%0d", i));

    doCmd(1'b0, 5'd5, 64'h0, refMem[5], 1'b0, 10, "backpressure read");

    doCmd(1'b1, 5'd7, 64'h1, 64'h1, 1'b0, 0, "pre-reset write");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd7; cmd_data = 64'h2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid-reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
    rvCount = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) rvCount++;
    end
    checkOutput("abandoned rsp count", 64'(rvCount), 64'd0);
    doCmd(1'b0, 5'd7, 64'h0, 64'h1, 1'b0, 0, "post-reset read");

    ld0 = ldCount; st0 = stCount;
    doCmd(1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "strobe wr1");
    doCmd(1'b0, 5'd12, 64'h0, refMem[12], 1'b0, 0, "strobe rd");
    doCmd(1'b1, 5'd13, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b0, 0, "strobe wr2");
`ifdef RF_DRV_VERIFY_EN
    checkOutput("ld strobes per w-r-w", 64'(ldCount - ld0), 64'd3);
`else
    checkOutput("ld strobes per w-r-w", 64'(ldCount - ld0), 64'd1);
`endif
    checkOutput("st strobes per w-r-w", 64'(stCount - st0), 64'd2);
    checkOutput("ld/st overlap", 64'(overlapCount), 64'd0);
    checkOutput("strobe width", 64'(widthErrCount), 64'd0);

    for (int i = 0; i < 30; i++) begin
      rWr   = 1'($urandom_range(0, 1));
      rAddr = 5'($urandom_range(0, 31));
      rData = {$urandom, $urandom};
      doCmd(rWr, rAddr, rData, rWr ? rData : refMem[rAddr], 1'b0, 0, $sformatf("rand%0d", i));
    end

`ifdef RF_DRV_VERIFY_EN
    doCmd(1'b1, 5'd9, 64'hA5, 64'hA5, 1'b0, 0, "verify ok");
    forceSdoZero = 1'b1;
    doCmd(1'b1, 5'd9, 64'hA5, 64'h0, 1'b1, 0, "verify forced");
    forceSdoZero = 1'b0;
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
